uart_rx_param: RTL and testbench

//  Parametrised UART receiver: successor to the fixed 8N1 receiver. Adds configurable word length,

---
 rtl/uart_rx_param_if.sv | 22 ++
 rtl/uart_rx_param.sv | 159 +++++++++++++++
 tb/tb_uart_rx_param.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Output handshake bundle of the parametrised UART receiver.
// The receiver drives the word and its flags; the consumer answers with data_ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output data_out, data_valid, frame_err, parity_err, overrun,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, frame_err, parity_err, overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable word/parity/stop format, 3-sample majority
// voting on an oversampled tick grid, error flags and a valid/ready output holding register.
module uart_rx_param #(
    parameter int CLK_HZ     = 81_250_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    uart_rx_param_if.master       bus,
    output logic                  busy
);
    localparam int DIV   = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  SMP_A     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_B     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  SMP_C     = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                 rx_m, rx_s, rx_d;
    logic [1:0]           warm;
    logic                 armed;
    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 smp_a, smp_b;
    logic [DATA_BITS-1:0] shift;
    logic                 ferr, perr, done;

    logic tick, decide, bit_end, maj, fall;

    assign tick    = (div_cnt == DIV_LAST);
    assign decide  = tick && (os_cnt == SMP_C);
    assign bit_end = tick && (os_cnt == OS_LAST);
    assign maj     = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign fall    = armed && rx_d && !rx_s;
    assign busy    = (state != S_IDLE);

    // warm marks when rx_s carries real line samples rather than its reset value,
    // so a line held low through reset is never mistaken for an idle-then-start edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make each flop take the pre-edge value of the
        // previous stage, so this is a genuine two-stage synchroniser plus edge history.
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
            warm <= 2'b00;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
            warm <= {warm[0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            armed          <= 1'b0;
            div_cnt        <= '0;
            os_cnt         <= '0;
            bit_idx        <= '0;
            smp_a          <= 1'b1;
            smp_b          <= 1'b1;
            shift          <= '0;
            ferr           <= 1'b0;
            perr           <= 1'b0;
            done           <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            done        <= 1'b0;
            bus.overrun <= 1'b0;
            div_cnt     <= tick ? '0 : div_cnt + 1'b1;
            if (state != S_IDLE && tick)
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            if (tick && os_cnt == SMP_A) smp_a <= rx_s;
            if (tick && os_cnt == SMP_B) smp_b <= rx_s;

            case (state)
                S_IDLE: begin
                    os_cnt  <= '0;
                    bit_idx <= '0;
                    if (rx_s && warm[1]) armed <= 1'b1;
                    if (fall) begin
                        state   <= S_START;
                        div_cnt <= '0;
                        ferr    <= 1'b0;
                        perr    <= 1'b0;
                    end
                end
                S_START: begin
                    if (decide && maj)  state <= S_IDLE;
                    else if (bit_end)   state <= S_DATA;
                end
                S_DATA: begin
                    if (decide) shift <= {maj, shift[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    // Expected bit is the data XOR, inverted for odd parity.
                    if (decide) perr <= maj ^ (^shift) ^ (PARITY == 1);
                    if (bit_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (decide) begin
                        if (!maj) ferr <= 1'b1;
                        if (bit_idx == STOP_LAST) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                            if (!maj || ferr) armed <= 1'b0;
                        end
                    end else if (bit_end) begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A completed frame beats a same-cycle acceptance; otherwise it is dropped.
            if (done) begin
                if (!bus.data_valid || bus.data_ready) begin
                    bus.data_out   <= shift;
                    bus.frame_err  <= ferr;
                    bus.parity_err <= perr;
                    bus.data_valid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end else if (bus.data_valid && bus.data_ready) begin
                bus.data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8N1 instance and a 7E2 instance on a scaled
// clock (64 clocks per bit), directed corner sequences, a vector table and random frames.
module tb_uart_rx_param;
    localparam int CLK_HZ  = 1_228_800;
    localparam int BAUD    = 19_200;
    localparam int BIT_CLK = 64;

    typedef struct {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } rec_t;

    typedef struct {
        logic [8:0] data;
        logic       par_bit;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic clk, rst, rx0, rx1, busy0, busy1;
    int   n_checks, n_fail, ovr0, ovr1;
    rec_t rx0_q[$], rx1_q[$], exp0_q[$], exp1_q[$];
    rec_t mon0_r, mon1_r;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(7)) if1 ();

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst), .rx(rx0), .bus(if0), .busy(busy0));

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(8),
                    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
        u1 (.clk(clk), .rst(rst), .rx(rx1), .bus(if1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every accepted word and every overrun pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && if0.data_valid && if0.data_ready) begin
            mon0_r.data = 9'(if0.data_out);
            mon0_r.ferr = if0.frame_err;
            mon0_r.perr = if0.parity_err;
            rx0_q.push_back(mon0_r);
        end
        if (!rst && if1.data_valid && if1.data_ready) begin
            mon1_r.data = 9'(if1.data_out);
            mon1_r.ferr = if1.frame_err;
            mon1_r.perr = if1.parity_err;
            rx1_q.push_back(mon1_r);
        end
        if (!rst && if0.overrun) ovr0++;
        if (!rst && if1.overrun) ovr1++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx0 = v; else rx1 = v;
        wait_clks(BIT_CLK);
    endtask

    task automatic idle(input int which, input int n);
        if (which == 0) rx0 = 1'b1; else rx1 = 1'b1;
        wait_clks(n);
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit, input int nstop,
                              input logic [1:0] stops);
        drive_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(which, data[i]);
        if (has_par) drive_bit(which, par_bit);
        for (int i = 0; i < nstop; i++) drive_bit(which, stops[i]);
    endtask

    // Frame-level model: count ones for parity, any low stop bit is a framing error.
    function automatic rec_t model(input logic [8:0] data, input int nbits, input int par_mode,
                                   input logic par_bit, input int nstop, input logic [1:0] stops);
        rec_t r;
        int   ones;
        r.data = data & 9'((1 << nbits) - 1);
        ones   = $countones(r.data) + int'(par_bit);
        r.perr = (par_mode == 0) ? 1'b0 : ((ones % 2) != ((par_mode == 1) ? 1 : 0));
        r.ferr = 1'b0;
        for (int i = 0; i < nstop; i++) if (!stops[i]) r.ferr = 1'b1;
        return r;
    endfunction

    vec_t vecs[6];

    initial begin
        logic [8:0] d;
        logic       pb;
        logic [1:0] st;
        int         gap, n0, n1, o0, o1;

        vecs[0] = '{9'h035, 1'b1, 2'b11, 9'h035, 1'b0, 1'b1};
        vecs[1] = '{9'h035, 1'b0, 2'b11, 9'h035, 1'b0, 1'b0};
        vecs[2] = '{9'h07F, 1'b1, 2'b11, 9'h07F, 1'b0, 1'b0};
        vecs[3] = '{9'h000, 1'b0, 2'b10, 9'h000, 1'b1, 1'b0};
        vecs[4] = '{9'h001, 1'b0, 2'b01, 9'h001, 1'b1, 1'b1};
        vecs[5] = '{9'h02A, 1'b1, 2'b11, 9'h02A, 1'b0, 1'b0};

        n_checks = 0; n_fail = 0; ovr0 = 0; ovr1 = 0;
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        if0.data_ready = 1'b0; if1.data_ready = 1'b1;
        wait_clks(4);
        @(negedge clk);
        check("reset flags u0", {28'd0, if0.data_valid, if0.frame_err, if0.parity_err, if0.overrun}, 32'd0);
        check("reset data u0", 32'(if0.data_out), 32'd0);
        check("reset busy", {30'd0, busy0, busy1}, 32'd0);
        check("reset valid u1", 32'(if1.data_valid), 32'd0);
        wait_clks(1);
        rst = 1'b0;
        wait_clks(BIT_CLK);

        // 1: plain 8N1 word, held until accepted
        send_frame(0, 9'h09D, 8, 0, 1'b0, 1, 2'b11);
        idle(0, BIT_CLK);
        @(negedge clk);
        check("t1 valid", 32'(if0.data_valid), 32'd1);
        check("t1 data", 32'(if0.data_out), 32'h9D);
        check("t1 errs", {30'd0, if0.frame_err, if0.parity_err}, 32'd0);
        check("t1 busy idle", 32'(busy0), 32'd0);
        wait_clks(1);
        if0.data_ready = 1'b1;
        @(negedge clk);
        check("t1 valid before edge", 32'(if0.data_valid), 32'd1);
        @(negedge clk);
        check("t1 valid cleared", 32'(if0.data_valid), 32'd0);
        wait_clks(1);
        if0.data_ready = 1'b0;

        // 2: stop bit low then line held low (break)
        send_frame(0, 9'h09D, 8, 0, 1'b0, 1, 2'b00);
        wait_clks(3 * BIT_CLK);
        @(negedge clk);
        check("t2 valid", 32'(if0.data_valid), 32'd1);
        check("t2 data", 32'(if0.data_out), 32'h9D);
        check("t2 frame_err", 32'(if0.frame_err), 32'd1);
        check("t2 busy during break", 32'(busy0), 32'd0);
        wait_clks(1);
        if0.data_ready = 1'b1;
        n0 = rx0_q.size();
        wait_clks(BIT_CLK);
        @(negedge clk);
        check("t2 break accepted once", rx0_q.size(), n0 + 1);
        check("t2 no frame in break", {30'd0, busy0, if0.data_valid}, 32'd0);
        idle(0, 2 * BIT_CLK);
        n0 = rx0_q.size();
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11);
        idle(0, BIT_CLK);
        check("t2 recovery count", rx0_q.size(), n0 + 1);
        if (rx0_q.size() > n0) begin
            check("t2 recovery data", 32'(rx0_q[n0].data), 32'h5A);
            check("t2 recovery ferr", 32'(rx0_q[n0].ferr), 32'd0);
        end

        // 3: short glitch, 4 sample ticks low
        n0 = rx0_q.size();
        rx0 = 1'b0;
        wait_clks(4);
        @(negedge clk);
        check("t3 busy on edge", 32'(busy0), 32'd1);
        wait_clks(12);
        rx0 = 1'b1;
        wait_clks(BIT_CLK);
        @(negedge clk);
        check("t3 busy back", 32'(busy0), 32'd0);
        check("t3 no word", {31'd0, if0.data_valid} + 32'(rx0_q.size() - n0), 32'd0);

        // 4: overrun with back-to-back frames
        if0.data_ready = 1'b0;
        o0 = ovr0;
        send_frame(0, 9'h041, 8, 0, 1'b0, 1, 2'b11);
        send_frame(0, 9'h042, 8, 0, 1'b0, 1, 2'b11);
        idle(0, BIT_CLK);
        @(negedge clk);
        check("t4 valid", 32'(if0.data_valid), 32'd1);
        check("t4 data kept", 32'(if0.data_out), 32'h41);
        check("t4 overrun pulses", ovr0 - o0, 32'd1);
        wait_clks(1);
        n0 = rx0_q.size();
        if0.data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4 valid cleared", 32'(if0.data_valid), 32'd0);
        wait_clks(2 * BIT_CLK);
        check("t4 single accept", rx0_q.size(), n0 + 1);
        if (rx0_q.size() > n0) check("t4 accepted word", 32'(rx0_q[n0].data), 32'h41);
        check("t4 no stale word", 32'(if0.data_valid), 32'd0);

        // 5: 7E2 vector table
        for (int i = 0; i < 6; i++) begin
            n1 = rx1_q.size();
            send_frame(1, vecs[i].data, 7, 1, vecs[i].par_bit, 2, vecs[i].stops);
            idle(1, BIT_CLK);
            check($sformatf("tbl%0d count", i), rx1_q.size(), n1 + 1);
            if (rx1_q.size() > n1) begin
                check($sformatf("tbl%0d data", i), 32'(rx1_q[n1].data), 32'(vecs[i].exp_data));
                check($sformatf("tbl%0d ferr", i), 32'(rx1_q[n1].ferr), 32'(vecs[i].exp_ferr));
                check($sformatf("tbl%0d perr", i), 32'(rx1_q[n1].perr), 32'(vecs[i].exp_perr));
            end
        end

        // 6: reset in data bit 3 with the line low
        if0.data_ready = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11);
        idle(0, BIT_CLK);
        @(negedge clk);
        check("t6 pre-reset valid", 32'(if0.data_valid), 32'd1);
        wait_clks(1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        rx0 = 1'b0;
        wait_clks(BIT_CLK / 2);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        @(negedge clk);
        check("t6 flags after reset", {28'd0, if0.data_valid, if0.frame_err, if0.parity_err, if0.overrun}, 32'd0);
        check("t6 data after reset", 32'(if0.data_out), 32'd0);
        wait_clks(BIT_CLK);
        @(negedge clk);
        check("t6 no start while low", {30'd0, busy0, if0.data_valid}, 32'd0);
        idle(0, 2 * BIT_CLK);
        if0.data_ready = 1'b1;
        n0 = rx0_q.size();
        send_frame(0, 9'h09D, 8, 0, 1'b0, 1, 2'b11);
        idle(0, 2 * BIT_CLK);
        check("t6 received once", rx0_q.size(), n0 + 1);
        if (rx0_q.size() > n0) check("t6 data", 32'(rx0_q[n0].data), 32'h9D);

        // Random 8N1 frames with random gaps, including back-to-back
        n0 = rx0_q.size();
        o0 = ovr0;
        exp0_q.delete();
        for (int i = 0; i < 16; i++) begin
            d   = 9'($urandom_range(0, 255));
            gap = $urandom_range(0, 2);
            exp0_q.push_back(model(d, 8, 0, 1'b0, 1, 2'b11));
            send_frame(0, d, 8, 0, 1'b0, 1, 2'b11);
            idle(0, gap * BIT_CLK);
        end
        idle(0, 2 * BIT_CLK);
        check("rand8n1 count", rx0_q.size(), n0 + 16);
        check("rand8n1 overrun", ovr0, o0);
        for (int i = 0; i < 16; i++) begin
            if (n0 + i < rx0_q.size())
                check($sformatf("rand8n1 %0d word", i),
                      {23'd0, rx0_q[n0 + i].data},
                      {23'd0, exp0_q[i].data});
        end

        // Random 7E2 frames with random parity and stop bits
        n1 = rx1_q.size();
        o1 = ovr1;
        exp1_q.delete();
        for (int i = 0; i < 16; i++) begin
            d   = 9'($urandom_range(0, 127));
            pb  = 1'($urandom_range(0, 1));
            st  = 2'($urandom_range(0, 3));
            gap = (st == 2'b11) ? $urandom_range(0, 1) : 1;
            exp1_q.push_back(model(d, 7, 2, pb, 2, st));
            send_frame(1, d, 7, 1, pb, 2, st);
            idle(1, gap * BIT_CLK);
        end
        idle(1, 2 * BIT_CLK);
        check("rand7e2 count", rx1_q.size(), n1 + 16);
        check("rand7e2 overrun", ovr1, o1);
        for (int i = 0; i < 16; i++) begin
            if (n1 + i < rx1_q.size())
                check($sformatf("rand7e2 %0d rec", i),
                      {21'd0, rx1_q[n1 + i].data, rx1_q[n1 + i].ferr, rx1_q[n1 + i].perr},
                      {21'd0, exp1_q[i].data, exp1_q[i].ferr, exp1_q[i].perr});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
